// File: rtl/byte_pair_pkg.sv
// byte_pair_pkg
//   Shared types and constants for the byte pair packer.
//   BYTE_W  : width of one input byte
//   WORD_W  : width of one assembled output word
//   state_t : packer occupancy (EMPTY / HALF / FULL)
package byte_pair_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // nothing held
      HALF  = 2'd1,   // first byte held, waiting for the second
      FULL  = 2'd2    // complete word held and offered downstream
   } state_t;

endpackage

// File: rtl/byte_pair_packer.sv
// byte_pair_packer
//   Collects two consecutive accepted bytes into one 16-bit word and offers
//   it on a valid/ready output. A partial byte can be discarded with flush.
//
//   Parameters
//     LOW_FIRST : 1 = first byte goes to __out0[7:0], 0 = to __out0[15:8]
//     CNT_W     : width of the consumed-word counter
//
//   Ports
//     clk, rst       : clock, synchronous active-high reset
//     __in0*         : byte input stream (valid/ready)
//     flush          : drop a held partial byte
//     __out0*        : word output stream (valid/ready), zero when not valid
//     __pending      : one byte held, word not yet complete
//     __words        : number of words consumed (wraps)
module byte_pair_packer
   import byte_pair_pkg::*;
#(
   parameter int unsigned LOW_FIRST = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] __in0,
   input  logic              __in0_valid,
   output logic              __in0_ready,
   input  logic              flush,
   output logic [WORD_W-1:0] __out0,
   output logic              __out0_valid,
   input  logic              __out0_ready,
   output logic              __pending,
   output logic [CNT_W-1:0]  __words
);

   state_t             state_q;
   logic [BYTE_W-1:0]  byte_q;
   logic [WORD_W-1:0]  word_q;
   logic [CNT_W-1:0]   words_q;

   logic byte_hs;
   logic word_hs;

   // In FULL a byte can only enter when the held word leaves in the same
   // cycle, which gives back-to-back words without a bubble.
   assign __in0_ready = !flush && ((state_q != FULL) || __out0_ready);
   assign byte_hs     = __in0_valid && __in0_ready;
   assign word_hs     = (state_q == FULL) && __out0_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         byte_q  <= '0;
         word_q  <= '0;
         words_q <= '0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (byte_hs) begin
                  byte_q  <= __in0;
                  state_q <= HALF;
               end
            end
            HALF: begin
               if (flush) begin
                  byte_q  <= '0;
                  state_q <= EMPTY;
               end else if (byte_hs) begin
                  if (LOW_FIRST != 0) word_q <= {__in0, byte_q};
                  else                word_q <= {byte_q, __in0};
                  state_q <= FULL;
               end
            end
            FULL: begin
               // word_q is cleared on exit so the output reads zero when idle
               if (word_hs) begin
                  word_q <= '0;
                  if (byte_hs) begin
                     byte_q  <= __in0;
                     state_q <= HALF;
                  end else begin
                     state_q <= EMPTY;
                  end
               end
            end
            default: state_q <= EMPTY;
         endcase

         if (word_hs) words_q <= words_q + CNT_W'(1);
      end
   end

   assign __out0       = word_q;
   assign __out0_valid = (state_q == FULL);
   assign __pending    = (state_q == HALF);
   assign __words      = words_q;

endmodule

// File: tb/tb_byte_pair_packer.sv
// Testbench for byte_pair_packer. Two instances share all inputs:
//   dut_a : LOW_FIRST=1, CNT_W=16
//   dut_b : LOW_FIRST=0, CNT_W=4 (narrow counter so wrap is reachable quickly)
module tb_byte_pair_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in0;
   logic        in0_valid;
   logic        flush;
   logic        out0_ready;

   logic        a_ready, a_valid, a_pend;
   logic [15:0] a_out, a_words;
   logic        b_ready, b_valid, b_pend;
   logic [15:0] b_out;
   logic [3:0]  b_words;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   byte_pair_packer #(.LOW_FIRST(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .__in0(in0), .__in0_valid(in0_valid),
      .__in0_ready(a_ready), .flush(flush), .__out0(a_out),
      .__out0_valid(a_valid), .__out0_ready(out0_ready),
      .__pending(a_pend), .__words(a_words));

   byte_pair_packer #(.LOW_FIRST(0), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .__in0(in0), .__in0_valid(in0_valid),
      .__in0_ready(b_ready), .flush(flush), .__out0(b_out),
      .__out0_valid(b_valid), .__out0_ready(out0_ready),
      .__pending(b_pend), .__words(b_words));

   typedef struct {
      logic [7:0]  in;
      logic        v;
      logic        fl;
      logic        orr;
      logic        e_rdy;
      logic        e_val;
      logic [15:0] e_outa;   // LOW_FIRST=1 word; the other instance sees it byte-swapped
      logic        e_pend;
      int          e_words;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [7:0] in, logic v, logic fl, logic orr,
                               logic e_rdy, logic e_val, logic [15:0] e_outa,
                               logic e_pend, int e_words);
      vec_t r;
      r.in = in; r.v = v; r.fl = fl; r.orr = orr;
      r.e_rdy = e_rdy; r.e_val = e_val; r.e_outa = e_outa;
      r.e_pend = e_pend; r.e_words = e_words;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic [7:0] in, logic v, logic fl, logic orr, logic r);
      in0 = in; in0_valid = v; flush = fl; out0_ready = orr; rst = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] swap(logic [15:0] w);
      return {w[7:0], w[15:8]};
   endfunction

   // Checks both instances' outputs against one set of expectations.
   task automatic chk_all(string tag, logic rdy, logic val, logic [15:0] outa,
                          logic pend, int words);
      logic [15:0] exp_a_words;
      logic [3:0]  exp_b_words;
      exp_a_words = 16'(words);
      exp_b_words = 4'(words);
      chk({tag, " a_ready"}, 32'(a_ready), 32'(rdy));
      chk({tag, " b_ready"}, 32'(b_ready), 32'(rdy));
      chk({tag, " a_valid"}, 32'(a_valid), 32'(val));
      chk({tag, " b_valid"}, 32'(b_valid), 32'(val));
      chk({tag, " a_out"},   32'(a_out),   32'(outa));
      chk({tag, " b_out"},   32'(b_out),   32'(swap(outa)));
      chk({tag, " a_pend"},  32'(a_pend),  32'(pend));
      chk({tag, " b_pend"},  32'(b_pend),  32'(pend));
      chk({tag, " a_words"}, 32'(a_words), 32'(exp_a_words));
      chk({tag, " b_words"}, 32'(b_words), 32'(exp_b_words));
   endtask

   // Three-cycle word: first byte, second byte, then consume with no new byte.
   task automatic send_word(logic [7:0] b0, logic [7:0] b1, int words_before);
      drive(b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      drive(b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk_all($sformatf("word %h%h", b1, b0), 1'b1, 1'b1, {b1, b0}, 1'b0, words_before);
      tick();
   endtask

   initial begin
      // Stimulus rows: inputs applied this cycle, expectations observed
      // in the same cycle before the clock edge.
      vecs.push_back(mk(8'h34,1,0,1, 1,0,16'h0000,0,0)); // EMPTY, accept 34
      vecs.push_back(mk(8'h12,1,0,1, 1,0,16'h0000,1,0)); // HALF, accept 12
      vecs.push_back(mk(8'h00,0,0,1, 1,1,16'h1234,0,0)); // FULL one cycle later
      vecs.push_back(mk(8'h00,0,0,1, 1,0,16'h0000,0,1)); // consumed
      vecs.push_back(mk(8'h56,1,0,1, 1,0,16'h0000,0,1));
      vecs.push_back(mk(8'h78,1,0,1, 1,0,16'h0000,1,1));
      for (int i = 0; i < 5; i++)                          // stalled FULL
         vecs.push_back(mk(8'h99,1,0,0, 0,1,16'h7856,0,1));
      vecs.push_back(mk(8'hAA,1,0,1, 1,1,16'h7856,0,1)); // consume + accept
      vecs.push_back(mk(8'h00,0,1,1, 0,0,16'h0000,1,2)); // HALF(AA), flush
      vecs.push_back(mk(8'h55,1,0,1, 1,0,16'h0000,0,2)); // EMPTY, accept 55
      vecs.push_back(mk(8'h77,1,1,1, 0,0,16'h0000,1,2)); // flush drops 55, 77 refused
      vecs.push_back(mk(8'h01,1,0,1, 1,0,16'h0000,0,2));
      vecs.push_back(mk(8'h02,1,0,1, 1,0,16'h0000,1,2));
      vecs.push_back(mk(8'h00,0,0,1, 1,1,16'h0201,0,2));
      vecs.push_back(mk(8'h00,0,1,0, 0,0,16'h0000,0,3)); // flush in EMPTY: no effect
      vecs.push_back(mk(8'h11,1,0,0, 1,0,16'h0000,0,3));
      vecs.push_back(mk(8'h22,1,0,0, 1,0,16'h0000,1,3));
      vecs.push_back(mk(8'h00,0,1,1, 0,1,16'h2211,0,3)); // flush in FULL, word consumed
      vecs.push_back(mk(8'h00,0,0,1, 1,0,16'h0000,0,4));

      // Reset
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      tick(); tick();
      @(negedge clk);
      chk_all("reset", 1'b1, 1'b0, 16'h0000, 1'b0, 0);
      tick();

      foreach (vecs[i]) begin
         drive(vecs[i].in, vecs[i].v, vecs[i].fl, vecs[i].orr, 1'b0);
         @(negedge clk);
         chk_all($sformatf("row%0d", i), vecs[i].e_rdy, vecs[i].e_val,
                 vecs[i].e_outa, vecs[i].e_pend, vecs[i].e_words);
         tick();
      end

      // Counter wrap on the 4-bit instance: 4 -> 15 -> 0 (16 on the wide one)
      for (int i = 0; i < 11; i++)
         send_word(8'(i * 2 + 1), 8'(i * 2 + 2), 4 + i);
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("words15 a", 32'(a_words), 32'd15);
      chk("words15 b", 32'(b_words), 32'd15);
      send_word(8'hBE, 8'hEF, 15);
      @(negedge clk);
      chk("wrap a", 32'(a_words), 32'd16);
      chk("wrap b", 32'(b_words), 32'd0);
      tick();

      // Reset while HALF: byte offered in same cycle is ignored
      drive(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      @(negedge clk);
      chk("half before rst", 32'(a_pend), 32'd1);
      drive(8'h6B, 1'b1, 1'b0, 1'b1, 1'b1); tick();
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk_all("rst in HALF", 1'b1, 1'b0, 16'h0000, 1'b0, 0);

      // Reset while FULL with ready high: word discarded, not counted
      drive(8'hC1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      drive(8'hC2, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      @(negedge clk);
      chk("full before rst", 32'(a_out), 32'h0000C2C1);
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1); tick();
      drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk_all("rst in FULL", 1'b1, 1'b0, 16'h0000, 1'b0, 0);

      // Fresh word after reset release
      send_word(8'hD4, 8'hE5, 0);
      @(negedge clk);
      chk_all("after rst word", 1'b1, 1'b0, 16'h0000, 1'b0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
